// File: rtl/iopmp_scan_checker.sv
// IOPMP source checker: one TOR entry is examined per cycle in index order, the first
// matching entry decides the permission, and the first denial is logged in RCD.
// Optional feature macro IOPMP_RCD_IRQ_EN: adds CTL.IE (bit1) and the registered irq_o output.
module iopmp_scan_checker #(
  parameter int unsigned NR_MD      = 2,
  parameter int unsigned NR_ENTRIES = 4,
  parameter int unsigned NR_MASTERS = 2,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                cfg_en_i,
  input  logic                cfg_we_i,
  input  logic [15:0]         cfg_addr_i,
  input  logic [63:0]         cfg_wdata_i,
  output logic [63:0]         cfg_rdata_o,
`ifdef IOPMP_RCD_IRQ_EN
  output logic                irq_o,
`endif
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [((NR_MASTERS > 1) ? $clog2(NR_MASTERS) : 1)-1:0] req_sid_i,
  input  logic [ADDR_W-1:0]   req_addr_i,
  input  logic                req_write_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic                rsp_allow_o
);

  localparam int unsigned NE   = NR_MD * NR_ENTRIES;
  localparam int unsigned SidW = (NR_MASTERS > 1) ? $clog2(NR_MASTERS) : 1;
  localparam int unsigned KW   = (NE > 1) ? $clog2(NE) : 1;

  typedef enum logic [1:0] {StIdle, StScan, StResp} state_e;

  state_e            state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [SidW-1:0]   sid_q, sid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic              allow_q, allow_d;

  logic              ctl_en_q, ctl_en_d;
  logic              ctl_ie_q, ctl_ie_d;
  logic              ctl_l_q, ctl_l_d;
  logic [NR_MD-1:0]  mdmask_q, mdmask_d;
  logic [NR_MD-1:0]  srcmd_md_q [NR_MASTERS];
  logic [NR_MD-1:0]  srcmd_md_d [NR_MASTERS];
  logic [NR_MASTERS-1:0] srcmd_l_q, srcmd_l_d;
  logic [ADDR_W-1:0] entry_addr_q [NE];
  logic [ADDR_W-1:0] entry_addr_d [NE];
  logic [NE-1:0]     entry_r_q, entry_r_d, entry_w_q, entry_w_d;
  logic [NE-1:0]     entry_a_q, entry_a_d, entry_l_q, entry_l_d;

  logic              rcd_v_q, rcd_v_d;
  logic              rcd_wr_q, rcd_wr_d;
  logic [7:0]        rcd_sid_q, rcd_sid_d;
  logic [ADDR_W-1:0] rcd_addr_q, rcd_addr_d;
  logic [63:0]       rdata_q, rdata_d;

  logic              cfg_wr;
  logic              rcd_clr;
  logic              deny_enter;
  logic              sel_perm;
  logic [NE-1:0]     entry_hit;
  logic [ADDR_W-1:0] entry_lo [NE];
  logic              unused_wdata;

  assign cfg_wr       = cfg_en_i && cfg_we_i;
  assign unused_wdata = ^cfg_wdata_i;

  // Per-entry TOR match of the latched request; entry k belongs to MD k / NR_ENTRIES.
  for (genvar k = 0; k < NE; k++) begin : g_entry
    if (k == 0) begin : g_first
      assign entry_lo[k] = '0;
    end else begin : g_rest
      assign entry_lo[k] = entry_addr_q[k-1];
    end
    assign entry_hit[k] = entry_a_q[k] && srcmd_md_q[sid_q][k / NR_ENTRIES] &&
                          (addr_q >= entry_lo[k]) && (addr_q < entry_addr_q[k]);
  end

  // Config register writes with lock and MD-mask protection.
  always_comb begin
    ctl_en_d     = ctl_en_q;
    ctl_ie_d     = ctl_ie_q;
    ctl_l_d      = ctl_l_q;
    mdmask_d     = mdmask_q;
    srcmd_md_d   = srcmd_md_q;
    srcmd_l_d    = srcmd_l_q;
    entry_addr_d = entry_addr_q;
    entry_r_d    = entry_r_q;
    entry_w_d    = entry_w_q;
    entry_a_d    = entry_a_q;
    entry_l_d    = entry_l_q;
    rcd_clr      = 1'b0;
    if (cfg_wr) begin
      if (cfg_addr_i == 16'h0000 && !ctl_l_q) begin
        ctl_en_d = cfg_wdata_i[0];
        ctl_l_d  = cfg_wdata_i[31];
`ifdef IOPMP_RCD_IRQ_EN
        ctl_ie_d = cfg_wdata_i[1];
`endif
      end
      if (cfg_addr_i == 16'h0008) rcd_clr = cfg_wdata_i[0];
      if (cfg_addr_i == 16'h0018 && !ctl_l_q) mdmask_d = cfg_wdata_i[NR_MD-1:0];
      for (int i = 0; i < NR_MASTERS; i++) begin
        if (cfg_addr_i == 16'h0100 + 16'(8 * i) && !srcmd_l_q[i]) begin
          // Masked MD bits keep their old value.
          srcmd_md_d[i] = (cfg_wdata_i[NR_MD-1:0] & ~mdmask_q) | (srcmd_md_q[i] & mdmask_q);
          srcmd_l_d[i]  = cfg_wdata_i[63];
        end
      end
      for (int k = 0; k < NE; k++) begin
        if (cfg_addr_i == 16'h1000 + 16'(8 * k) && !entry_l_q[k]) begin
          entry_addr_d[k] = cfg_wdata_i[ADDR_W-1:0];
        end
        if (cfg_addr_i == 16'h2000 + 16'(8 * k) && !entry_l_q[k]) begin
          entry_r_d[k] = cfg_wdata_i[0];
          entry_w_d[k] = cfg_wdata_i[1];
          entry_a_d[k] = cfg_wdata_i[3];
          entry_l_d[k] = cfg_wdata_i[7];
        end
      end
    end
  end

  // Registered read mux; idle cycles return zero.
  always_comb begin
    rdata_d = '0;
    if (cfg_en_i && !cfg_we_i) begin
      if (cfg_addr_i == 16'h0000) rdata_d = {32'h0, ctl_l_q, 29'h0, ctl_ie_q, ctl_en_q};
      if (cfg_addr_i == 16'h0008) rdata_d = {48'h0, rcd_sid_q, 6'h0, rcd_wr_q, rcd_v_q};
      if (cfg_addr_i == 16'h0010) rdata_d = 64'(rcd_addr_q);
      if (cfg_addr_i == 16'h0018) rdata_d = 64'(mdmask_q);
      for (int i = 0; i < NR_MASTERS; i++) begin
        if (cfg_addr_i == 16'h0100 + 16'(8 * i)) rdata_d = {srcmd_l_q[i], 63'(srcmd_md_q[i])};
      end
      for (int k = 0; k < NE; k++) begin
        if (cfg_addr_i == 16'h1000 + 16'(8 * k)) rdata_d = 64'(entry_addr_q[k]);
        if (cfg_addr_i == 16'h2000 + 16'(8 * k)) begin
          rdata_d = {56'h0, entry_l_q[k], 3'h0, entry_a_q[k], 1'b0, entry_w_q[k], entry_r_q[k]};
        end
      end
    end
  end

  // Request FSM: latch in IDLE, walk entries one per cycle in SCAN, hold result in RESP.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    sid_d      = sid_q;
    addr_d     = addr_q;
    write_d    = write_q;
    allow_d    = allow_q;
    deny_enter = 1'b0;
    sel_perm   = write_q ? entry_w_q[k_q] : entry_r_q[k_q];
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          sid_d   = req_sid_i;
          addr_d  = req_addr_i;
          write_d = req_write_i;
          k_d     = '0;
          if (!ctl_en_q) begin
            state_d = StResp;
            allow_d = 1'b1;
          end else if (32'(req_sid_i) >= NR_MASTERS) begin
            state_d    = StResp;
            allow_d    = 1'b0;
            deny_enter = 1'b1;
          end else begin
            state_d = StScan;
          end
        end
      end
      StScan: begin
        if (entry_hit[k_q]) begin
          state_d    = StResp;
          allow_d    = sel_perm;
          deny_enter = !sel_perm;
        end else if (k_q == KW'(NE - 1)) begin
          state_d    = StResp;
          allow_d    = 1'b0;
          deny_enter = 1'b1;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      StResp: begin
        if (rsp_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Error record: first denial is sticky; a capture in the clearing cycle still lands.
  always_comb begin
    rcd_v_d    = rcd_v_q;
    rcd_wr_d   = rcd_wr_q;
    rcd_sid_d  = rcd_sid_q;
    rcd_addr_d = rcd_addr_q;
    if (rcd_clr) rcd_v_d = 1'b0;
    if (deny_enter && (!rcd_v_q || rcd_clr)) begin
      rcd_v_d    = 1'b1;
      rcd_wr_d   = write_d;
      rcd_sid_d  = 8'(sid_d);
      rcd_addr_d = addr_d;
    end
  end

  // State and register storage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      k_q        <= '0;
      sid_q      <= '0;
      addr_q     <= '0;
      write_q    <= 1'b0;
      allow_q    <= 1'b0;
      ctl_en_q   <= 1'b0;
      ctl_ie_q   <= 1'b0;
      ctl_l_q    <= 1'b0;
      mdmask_q   <= '0;
      srcmd_l_q  <= '0;
      for (int i = 0; i < NR_MASTERS; i++) srcmd_md_q[i] <= '0;
      for (int k = 0; k < NE; k++) entry_addr_q[k] <= '0;
      entry_r_q  <= '0;
      entry_w_q  <= '0;
      entry_a_q  <= '0;
      entry_l_q  <= '0;
      rcd_v_q    <= 1'b0;
      rcd_wr_q   <= 1'b0;
      rcd_sid_q  <= '0;
      rcd_addr_q <= '0;
      rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      sid_q        <= sid_d;
      addr_q       <= addr_d;
      write_q      <= write_d;
      allow_q      <= allow_d;
      ctl_en_q     <= ctl_en_d;
      ctl_ie_q     <= ctl_ie_d;
      ctl_l_q      <= ctl_l_d;
      mdmask_q     <= mdmask_d;
      srcmd_l_q    <= srcmd_l_d;
      srcmd_md_q   <= srcmd_md_d;
      entry_addr_q <= entry_addr_d;
      entry_r_q    <= entry_r_d;
      entry_w_q    <= entry_w_d;
      entry_a_q    <= entry_a_d;
      entry_l_q    <= entry_l_d;
      rcd_v_q      <= rcd_v_d;
      rcd_wr_q     <= rcd_wr_d;
      rcd_sid_q    <= rcd_sid_d;
      rcd_addr_q   <= rcd_addr_d;
      rdata_q      <= rdata_d;
    end
  end

`ifdef IOPMP_RCD_IRQ_EN
  logic irq_q;

  // Interrupt follows the logged-error flag one cycle later.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) irq_q <= 1'b0;
    else         irq_q <= rcd_v_q && ctl_ie_q;
  end

  assign irq_o = irq_q;
`endif

  assign req_ready_o = (state_q == StIdle);
  assign rsp_valid_o = (state_q == StResp);
  assign rsp_allow_o = rsp_valid_o && allow_q;
  assign cfg_rdata_o = rdata_q;

endmodule

// File: tb/tb_iopmp_scan_checker.sv
// Self-checking bench for iopmp_scan_checker with a behavioural register/permission model.
module tb_iopmp_scan_checker;

  localparam int NM  = 2;
  localparam int NRE = 4;
  localparam int NE  = 8;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cfg_en_i = 1'b0;
  logic        cfg_we_i = 1'b0;
  logic [15:0] cfg_addr_i = '0;
  logic [63:0] cfg_wdata_i = '0;
  logic [63:0] cfg_rdata_o;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [0:0]  req_sid_i = '0;
  logic [31:0] req_addr_i = '0;
  logic        req_write_i = 1'b0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic        rsp_allow_o;

  int errors = 0;
  int checks = 0;

  // Model state
  logic        m_en, m_ctl_l;
  logic [1:0]  m_mdmask;
  logic [1:0]  m_srcmd [NM];
  logic        m_srcmd_l [NM];
  logic [31:0] m_eaddr [NE];
  logic [7:0]  m_ecfg [NE];
  logic        mv, mwr;
  logic [7:0]  msid;
  logic [31:0] maddr;

  iopmp_scan_checker #(
    .NR_MD(2),
    .NR_ENTRIES(4),
    .NR_MASTERS(2),
    .ADDR_W(32)
  ) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .cfg_en_i(cfg_en_i),
    .cfg_we_i(cfg_we_i),
    .cfg_addr_i(cfg_addr_i),
    .cfg_wdata_i(cfg_wdata_i),
    .cfg_rdata_o(cfg_rdata_o),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_sid_i(req_sid_i),
    .req_addr_i(req_addr_i),
    .req_write_i(req_write_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i),
    .rsp_allow_o(rsp_allow_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic m_reset();
    m_en = 0; m_ctl_l = 0; m_mdmask = 0;
    for (int i = 0; i < NM; i++) begin m_srcmd[i] = 0; m_srcmd_l[i] = 0; end
    for (int k = 0; k < NE; k++) begin m_eaddr[k] = 0; m_ecfg[k] = 0; end
    mv = 0; mwr = 0; msid = 0; maddr = 0;
  endtask

  task automatic m_write(input logic [15:0] a, input logic [63:0] d);
    if (a == 16'h0000 && !m_ctl_l) begin m_en = d[0]; m_ctl_l = d[31]; end
    else if (a == 16'h0008 && d[0]) mv = 1'b0;
    else if (a == 16'h0018 && !m_ctl_l) m_mdmask = d[1:0];
    for (int i = 0; i < NM; i++) begin
      if (a == 16'h0100 + 16'(8 * i) && !m_srcmd_l[i]) begin
        m_srcmd[i]   = (d[1:0] & ~m_mdmask) | (m_srcmd[i] & m_mdmask);
        m_srcmd_l[i] = d[63];
      end
    end
    for (int k = 0; k < NE; k++) begin
      if (a == 16'h1000 + 16'(8 * k) && !m_ecfg[k][7]) m_eaddr[k] = d[31:0];
      else if (a == 16'h2000 + 16'(8 * k) && !m_ecfg[k][7]) m_ecfg[k] = d[7:0] & 8'h8B;
    end
  endtask

  function automatic logic [63:0] m_read(input logic [15:0] a);
    logic [63:0] r;
    r = '0;
    if (a == 16'h0000) r = (64'(m_ctl_l) << 31) | 64'(m_en);
    if (a == 16'h0008) r = (64'(msid) << 8) | (64'(mwr) << 1) | 64'(mv);
    if (a == 16'h0010) r = 64'(maddr);
    if (a == 16'h0018) r = 64'(m_mdmask);
    for (int i = 0; i < NM; i++)
      if (a == 16'h0100 + 16'(8 * i)) r = (64'(m_srcmd_l[i]) << 63) | 64'(m_srcmd[i]);
    for (int k = 0; k < NE; k++) begin
      if (a == 16'h1000 + 16'(8 * k)) r = 64'(m_eaddr[k]);
      if (a == 16'h2000 + 16'(8 * k)) r = 64'(m_ecfg[k]);
    end
    return r;
  endfunction

  // Expected decision and cycles from handshake to rsp_valid.
  function automatic void m_eval(input int sid, input logic [31:0] addr, input bit wr,
                                 output bit allow, output int lat);
    logic [31:0] lo;
    allow = 1'b0;
    lat   = 1 + NE;
    if (!m_en) begin allow = 1'b1; lat = 1; return; end
    for (int k = 0; k < NE; k++) begin
      lo = (k == 0) ? 32'h0 : m_eaddr[k-1];
      if (m_srcmd[sid][k / NRE] && m_ecfg[k][3] && addr >= lo && addr < m_eaddr[k]) begin
        allow = wr ? m_ecfg[k][1] : m_ecfg[k][0];
        lat   = 2 + k;
        return;
      end
    end
  endfunction

  task automatic cfg_write(input logic [15:0] a, input logic [63:0] d);
    @(negedge clk_i);
    cfg_en_i = 1; cfg_we_i = 1; cfg_addr_i = a; cfg_wdata_i = d;
    @(negedge clk_i);
    cfg_en_i = 0; cfg_we_i = 0;
    m_write(a, d);
  endtask

  task automatic cfg_read(input logic [15:0] a, output logic [63:0] d);
    @(negedge clk_i);
    cfg_en_i = 1; cfg_we_i = 0; cfg_addr_i = a;
    @(negedge clk_i);
    cfg_en_i = 0;
    d = cfg_rdata_o;
  endtask

  // One request: checks ready, latency, allow, optional stall stability and completion.
  task automatic do_req(input int sid, input logic [31:0] addr, input bit wr, input int stall,
                        input string tag);
    bit e_allow;
    int e_lat;
    int lat;
    m_eval(sid, addr, wr, e_allow, e_lat);
    @(negedge clk_i);
    checks++;
    if (req_ready_o !== 1'b1) begin
      errors++; $display("FAIL %s req_ready: got %b want 1", tag, req_ready_o);
    end
    req_valid_i = 1; req_sid_i = 1'(sid); req_addr_i = addr; req_write_i = wr;
    @(negedge clk_i);
    req_valid_i = 0;
    lat = 1;
    while (rsp_valid_o !== 1'b1 && lat < 40) begin @(negedge clk_i); lat++; end
    checks++;
    if (lat != e_lat) begin
      errors++; $display("FAIL %s latency: got %0d want %0d", tag, lat, e_lat);
    end
    checks++;
    if (rsp_allow_o !== e_allow) begin
      errors++; $display("FAIL %s allow: got %b want %b", tag, rsp_allow_o, e_allow);
    end
    for (int i = 0; i < stall; i++) begin
      @(negedge clk_i);
      checks++;
      if (rsp_valid_o !== 1'b1 || rsp_allow_o !== e_allow || req_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL %s stall%0d: got v=%b a=%b rdy=%b want v=1 a=%b rdy=0", tag, i,
                 rsp_valid_o, rsp_allow_o, req_ready_o, e_allow);
      end
    end
    rsp_ready_i = 1;
    @(negedge clk_i);
    rsp_ready_i = 0;
    checks++;
    if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL %s done: got v=%b rdy=%b want v=0 rdy=1", tag, rsp_valid_o, req_ready_o);
    end
    if (!e_allow && !mv) begin mv = 1; mwr = wr; msid = 8'(sid); maddr = addr; end
  endtask

  task automatic test_reset();
    logic [63:0] d;
    rst_ni = 0;
    repeat (2) @(negedge clk_i);
    cfg_en_i = 1; cfg_addr_i = 16'h0008;
    @(negedge clk_i);
    cfg_en_i = 0;
    checks++;
    if (req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0 || rsp_allow_o !== 1'b0 ||
        cfg_rdata_o !== 64'h0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b v=%b a=%b rd=%h want 1 0 0 0",
               req_ready_o, rsp_valid_o, rsp_allow_o, cfg_rdata_o);
    end
    rst_ni = 1;
    m_reset();
    cfg_read(16'h0000, d);
    checks++;
    if (d !== 64'h0) begin errors++; $display("FAIL reset_ctl: got %h want 0", d); end
    cfg_read(16'h2008, d);
    checks++;
    if (d !== 64'h0) begin errors++; $display("FAIL reset_cfg1: got %h want 0", d); end
  endtask

  task automatic test_disabled();
    logic [63:0] d;
    do_req(0, 32'h1234, 0, 0, "disabled");
    cfg_read(16'h0008, d);
    checks++;
    if (d !== 64'h0) begin errors++; $display("FAIL disabled_rcd: got %h want 0", d); end
  endtask

  task automatic test_basic_entry();
    logic [63:0] d;
    cfg_write(16'h0000, 64'h1);
    cfg_write(16'h0100, 64'h1);
    cfg_write(16'h1000, 64'h1000);
    cfg_write(16'h2000, 64'h09);
    do_req(0, 32'h0800, 0, 0, "basic_read");
    do_req(0, 32'h0800, 1, 0, "basic_write");
    cfg_read(16'h0008, d);
    checks++;
    if (d !== 64'h3) begin errors++; $display("FAIL basic_rcd: got %h want 3", d); end
    cfg_read(16'h0010, d);
    checks++;
    if (d !== 64'h800) begin errors++; $display("FAIL basic_rcd_addr: got %h want 800", d); end
  endtask

  task automatic test_md_skip();
    logic [63:0] d;
    cfg_write(16'h0108, 64'h2);
    cfg_write(16'h1020, 64'h2000);
    cfg_write(16'h2020, 64'h0B);
    cfg_write(16'h0008, 64'h1);
    do_req(1, 32'h1800, 1, 0, "md_skip_write");
    do_req(1, 32'h3000, 0, 0, "md_nomatch");
    cfg_read(16'h0008, d);
    checks++;
    if (d !== 64'h101) begin errors++; $display("FAIL md_rcd: got %h want 101", d); end
  endtask

  task automatic test_rcd_sticky();
    logic [63:0] d;
    cfg_write(16'h0008, 64'h1);
    do_req(0, 32'h0A00, 1, 0, "deny1");
    do_req(0, 32'h0C00, 1, 0, "deny2");
    cfg_read(16'h0010, d);
    checks++;
    if (d !== 64'hA00) begin errors++; $display("FAIL sticky_addr: got %h want a00", d); end
    cfg_write(16'h0008, 64'h1);
    cfg_read(16'h0008, d);
    checks++;
    if (d[0] !== 1'b0) begin errors++; $display("FAIL w1c_clear: got %h want v=0", d); end
    do_req(0, 32'h1100, 0, 0, "recapture");
    cfg_read(16'h0010, d);
    checks++;
    if (d !== 64'h1100) begin errors++; $display("FAIL recapture_addr: got %h want 1100", d); end
    // Clear lands on the same edge the FSM enters RESP with a denial.
    @(negedge clk_i);
    req_valid_i = 1; req_sid_i = 0; req_addr_i = 32'h0900; req_write_i = 1;
    @(negedge clk_i);
    req_valid_i = 0;
    cfg_en_i = 1; cfg_we_i = 1; cfg_addr_i = 16'h0008; cfg_wdata_i = 64'h1;
    @(negedge clk_i);
    cfg_en_i = 0; cfg_we_i = 0;
    checks++;
    if (rsp_valid_o !== 1'b1 || rsp_allow_o !== 1'b0) begin
      errors++; $display("FAIL collide_rsp: got v=%b a=%b want 1 0", rsp_valid_o, rsp_allow_o);
    end
    rsp_ready_i = 1;
    @(negedge clk_i);
    rsp_ready_i = 0;
    mv = 1; mwr = 1; msid = 0; maddr = 32'h0900;
    cfg_read(16'h0008, d);
    checks++;
    if (d !== 64'h3) begin errors++; $display("FAIL collide_rcd: got %h want 3", d); end
    cfg_read(16'h0010, d);
    checks++;
    if (d !== 64'h900) begin errors++; $display("FAIL collide_addr: got %h want 900", d); end
  endtask

  task automatic test_random();
    logic [63:0] d;
    logic [31:0] a;
    int sid;
    bit wr;
    logic [31:0] addr;
    cfg_write(16'h0000, 64'h1);
    cfg_write(16'h0018, 64'h0);
    for (int i = 0; i < NM; i++) cfg_write(16'h0100 + 16'(8 * i), 64'($urandom_range(3)));
    a = 0;
    for (int k = 0; k < NE; k++) begin
      a = a + $urandom_range(32'h400);
      if ($urandom_range(7) == 0) a = $urandom_range(32'h2000);
      cfg_write(16'h1000 + 16'(8 * k), 64'(a));
      cfg_write(16'h2000 + 16'(8 * k), 64'($urandom & 32'h0B));
    end
    for (int n = 0; n < 40; n++) begin
      sid  = int'($urandom_range(1));
      wr   = 1'($urandom_range(1));
      addr = $urandom_range(a + 32'h200);
      do_req(sid, addr, wr, 0, "random");
      cfg_read(16'h0008, d);
      checks++;
      if (d !== m_read(16'h0008)) begin
        errors++; $display("FAIL random_rcd: got %h want %h", d, m_read(16'h0008));
      end
      cfg_read(16'h0010, d);
      checks++;
      if (d !== m_read(16'h0010)) begin
        errors++; $display("FAIL random_rcd_addr: got %h want %h", d, m_read(16'h0010));
      end
      if ($urandom_range(3) == 0) cfg_write(16'h0008, 64'h1);
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 6; n++) do_req(n % 2, 32'(n) * 32'h300, 1'(n / 2), 0, "b2b");
  endtask

  task automatic test_locks_stall();
    logic [63:0] d;
    cfg_write(16'h1000, 64'h1000);
    cfg_write(16'h2000, 64'h89);
    cfg_write(16'h1000, 64'hFFFF);
    cfg_write(16'h2000, 64'h0B);
    cfg_read(16'h1000, d);
    checks++;
    if (d !== 64'h1000) begin errors++; $display("FAIL entry_lock_addr: got %h want 1000", d); end
    cfg_read(16'h2000, d);
    checks++;
    if (d !== 64'h89) begin errors++; $display("FAIL entry_lock_cfg: got %h want 89", d); end
    @(negedge clk_i);
    checks++;
    if (cfg_rdata_o !== 64'h0) begin
      errors++; $display("FAIL rdata_idle: got %h want 0", cfg_rdata_o);
    end
    cfg_write(16'h0100, 64'h1);
    cfg_write(16'h0018, 64'h1);
    cfg_write(16'h0100, 64'h2);
    cfg_read(16'h0100, d);
    checks++;
    if (d !== 64'h3) begin errors++; $display("FAIL mdmask_keep: got %h want 3", d); end
    cfg_write(16'h0000, 64'h3);
    cfg_read(16'h0000, d);
    checks++;
    if (d !== 64'h1) begin errors++; $display("FAIL ctl_ie_absent: got %h want 1", d); end
    cfg_write(16'h0000, 64'h8000_0001);
    cfg_write(16'h0000, 64'h0);
    cfg_write(16'h0018, 64'h0);
    cfg_read(16'h0000, d);
    checks++;
    if (d !== 64'h8000_0001) begin errors++; $display("FAIL ctl_lock: got %h want 80000001", d); end
    cfg_read(16'h0018, d);
    checks++;
    if (d !== 64'h1) begin errors++; $display("FAIL mdmask_lock: got %h want 1", d); end
    cfg_write(16'h0108, 64'h8000_0000_0000_0001);
    cfg_write(16'h0108, 64'h2);
    cfg_read(16'h0108, d);
    checks++;
    if (d !== 64'h8000_0000_0000_0001) begin
      errors++; $display("FAIL srcmd_lock: got %h want 8000000000000001", d);
    end
    cfg_read(16'h0020, d);
    checks++;
    if (d !== 64'h0) begin errors++; $display("FAIL unmapped: got %h want 0", d); end
    do_req(0, 32'h0800, 0, 5, "stall_allow");
    do_req(0, 32'hFFFF_FF00, 0, 5, "stall_deny");
  endtask

  task automatic test_reset_mid_scan();
    logic [63:0] d;
    bit seen;
    @(negedge clk_i);
    req_valid_i = 1; req_sid_i = 0; req_addr_i = 32'hFFFF_FF00; req_write_i = 0;
    @(negedge clk_i);
    req_valid_i = 0;
    repeat (2) @(negedge clk_i);
    rst_ni = 0;
    #1;
    checks++;
    if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
      errors++; $display("FAIL midreset_out: got v=%b rdy=%b want 0 1", rsp_valid_o, req_ready_o);
    end
    repeat (2) @(negedge clk_i);
    rst_ni = 1;
    m_reset();
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_i);
      if (rsp_valid_o !== 1'b0) seen = 1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL midreset_rsp: got rsp_valid=1 want 0"); end
    checks++;
    if (req_ready_o !== 1'b1) begin
      errors++; $display("FAIL midreset_ready: got %b want 1", req_ready_o);
    end
    cfg_read(16'h0008, d);
    checks++;
    if (d !== 64'h0) begin errors++; $display("FAIL midreset_rcd: got %h want 0", d); end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_disabled();
    test_basic_entry();
    test_md_skip();
    test_rcd_sticky();
    test_random();
    test_back_to_back();
    test_locks_stall();
    test_reset_mid_scan();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/iopmp_scan_checker.md
IOPMP_SCAN_CHECKER -- requirements
Module: iopmp_scan_checker

Interface
REQ-001 SHALL have parameter NR_MD, default 2: number of memory domains (MD).
REQ-002 SHALL have parameter NR_ENTRIES, default 4: entries per MD; total entries NE = NR_MD*NR_ENTRIES; MD m owns entries m*NR_ENTRIES..(m+1)*NR_ENTRIES-1.
REQ-003 SHALL have parameter NR_MASTERS, default 2: number of source IDs (SID).
REQ-004 SHALL have parameter ADDR_W, default 32: request/entry address width.
REQ-005 SHALL have clk_i, input, 1: clock.
REQ-006 SHALL have rst_ni, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have cfg_en_i / cfg_we_i, input, 1 each: config access strobe / write select.
REQ-008 SHALL have cfg_addr_i, input, 16, byte offset; cfg_wdata_i, input, 64; cfg_rdata_o, output, 64.
REQ-009 SHALL have req_valid_i, input, 1; req_ready_o, output, 1; req_sid_i, input, max(1,clog2(NR_MASTERS)); req_addr_i, input, ADDR_W; req_write_i, input, 1 (1=write, 0=read).
REQ-010 SHALL have rsp_valid_o, output, 1; rsp_ready_i, input, 1; rsp_allow_o, output, 1.

Function
REQ-011 Register map SHALL be: 0x000 CTL (bit0 EN, bit31 L); 0x008 RCD (bit0 V, bit1 WR, bits 15:8 SID); 0x010 RCD_ADDR; 0x018 MDMASK (bits NR_MD-1:0); 0x100+8i SRCMD[i] (bits NR_MD-1:0 MD membership, bit63 L); 0x1000+8k ENTRY_ADDR[k]; 0x2000+8k ENTRY_CFG[k] (bit0 R, bit1 W, bit3 A enable, bit7 L).
REQ-012 Config writes SHALL take effect the cycle after cfg_en_i&&cfg_we_i; unmapped/out-of-range offsets ignored.
REQ-013 cfg_rdata_o SHALL be registered: valid the cycle after cfg_en_i&&!cfg_we_i, 0 otherwise; unmapped offsets read 0.
REQ-014 CTL.L=1 SHALL block writes to CTL and MDMASK; ENTRY_CFG[k].L=1 blocks writes to ENTRY_ADDR[k] and ENTRY_CFG[k]; SRCMD[i].L=1 blocks writes to SRCMD[i].
REQ-015 SRCMD[i] membership bits whose MDMASK bit is 1 SHALL be unchangeable by writes.
REQ-016 Entry k SHALL match (TOR) when lo <= req_addr < ENTRY_ADDR[k], lo = ENTRY_ADDR[k-1] (0 for k=0), unsigned ADDR_W compare; A=0 never matches.
REQ-017 FSM SHALL have states IDLE, SCAN, RESP; req_ready_o=1 only in IDLE.
REQ-018 IDLE: on req_valid_i&&req_ready_o (cycle T) SID/addr/write SHALL be latched; if CTL.EN=0 -> RESP with allow=1; if SID>=NR_MASTERS -> RESP with allow=0; else -> SCAN with k=0.
REQ-019 SCAN SHALL examine entry k in cycle T+1+k using live register values, skipping entries whose MD is not in SRCMD[SID].
REQ-020 First (lowest-index) match SHALL end the scan: allow = R (read) or W (write) bit of that entry; -> RESP.
REQ-021 No match after k=NE-1 SHALL give allow=0; rsp_valid_o rises at T+1+NE.
REQ-022 RESP: rsp_valid_o=1 with stable rsp_allow_o until rsp_ready_i; on handshake -> IDLE; req_ready_o=1 the following cycle.
REQ-023 On entering RESP with allow=0 and RCD.V=0, RCD SHALL capture SID, WR, and RCD_ADDR the request address, setting V=1; with V=1 no capture (first error sticky).
REQ-024 Writing RCD with wdata bit0=1 SHALL clear V (W1C); simultaneous clear and capture: capture wins.

Reset
REQ-025 On rst_ni low, all registers SHALL clear to 0, FSM to IDLE; req_ready_o=1, rsp_valid_o=0, rsp_allow_o=0, cfg_rdata_o=0 while in reset.
REQ-026 Reset mid-SCAN/RESP SHALL drop the in-flight request with no response and no RCD capture.

Configuration
REQ-027 With IOPMP_RCD_IRQ_EN defined: CTL bit1 IE writable, output irq_o (1 bit) = RCD.V && CTL.IE, registered, reset 0.
REQ-028 Without IOPMP_RCD_IRQ_EN: no irq_o port, CTL bit1 reads 0 and ignores writes.

Verification (NR_MD=2, NR_ENTRIES=4, NR_MASTERS=2, ADDR_W=32)
REQ-029 CTL.EN=0, read SID0 addr 0x1234 -> rsp_valid at T+1, allow=1, RCD.V=0.
REQ-030 EN=1, SRCMD[0]=0b01, ENTRY_ADDR[0]=0x1000, CFG[0]=0x09, read 0x0800 -> allow=1 at T+2; write 0x0800 -> allow=0 at T+2, RCD=V1/WR1/SID0, RCD_ADDR=0x0800.
REQ-031 SRCMD[1]=0b10, ENTRY_ADDR[4]=0x2000, CFG[4]=0x0B, SID1 write 0x1800 (entries 0-3 skipped) -> allow=1 at T+6; SID1 read 0x3000 -> allow=0 at T+9.
REQ-032 Two denials back-to-back -> RCD holds first; write RCD bit0=1 -> V=0; next denial recaptured; clear and capture same cycle -> V=1.
REQ-033 CFG[0].L=1 then write ENTRY_ADDR[0]=0xFFFF -> reads back 0x1000; MDMASK=0b01, write SRCMD[0]=0b10 -> reads 0b01 | 0b10 unchanged bit0 kept; rsp_ready_i low 5 cycles -> rsp_valid/allow stable, req_ready_o=0.
REQ-034 rst_ni low during SCAN -> rsp_valid_o=0, RCD.V=0, req_ready_o=1 after release.
